// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
// Sequences a W-bit addition through an external combinational 8-bit byte
// adder, one byte per cycle, LSB first, with the carry chained between bytes.
// Operands arrive on a valid/ready handshake; the assembled sum, the final
// carry and the signed overflow flag leave on a second valid/ready handshake.

module byte_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            cin_r;
    logic            carry_r;
    logic [W-1:0]    sum_r;
    logic [W-1:0]    out_sum_r;
    logic            out_cout_r;
    logic            out_ovf_r;
    logic            in_ready_r;
    logic            out_valid_r;

    // Bit offset of the current byte inside the W-bit words.
    logic [IW+2:0]   byte_off_s;
    logic            last_byte_s;
    logic [W-1:0]    sum_next_s;
    logic            ovf_s;
    logic [7:0]      add_a_s;
    logic [7:0]      add_b_s;
    logic            add_cin_s;

    assign byte_off_s  = {idx_r, 3'b000};
    assign last_byte_s = (idx_r == IW'(NBYTES - 1));

    // Signed overflow: operands agree in sign but the MSB of the result differs.
    assign ovf_s = (a_r[W-1] == b_r[W-1]) && (add_sum[7] != a_r[W-1]);

    // Byte adder operand mux: only the ADD state presents live operands.
    always_comb begin
        add_a_s   = 8'd0;
        add_b_s   = 8'd0;
        add_cin_s = 1'b0;
        case (state_r)
            ADD: begin
                add_a_s   = a_r[byte_off_s +: 8];
                add_b_s   = b_r[byte_off_s +: 8];
                add_cin_s = (idx_r == '0) ? cin_r : carry_r;
            end
            default: begin
                add_a_s   = 8'd0;
                add_b_s   = 8'd0;
                add_cin_s = 1'b0;
            end
        endcase
    end

    // Partial sum with the current byte adder result merged into its slot.
    always_comb begin
        sum_next_s = sum_r;
        if (state_r == ADD) begin
            sum_next_s[byte_off_s +: 8] = add_sum;
        end else begin
            sum_next_s = sum_r;
        end
    end

    // Control FSM with operand, partial-sum and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cin_r       <= 1'b0;
            carry_r     <= 1'b0;
            sum_r       <= '0;
            out_sum_r   <= '0;
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        cin_r      <= in_cin;
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ADD;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ADD: begin
                    sum_r   <= sum_next_s;
                    carry_r <= add_cout;
                    if (last_byte_s) begin
                        out_sum_r   <= sum_next_s;
                        out_cout_r  <= add_cout;
                        out_ovf_r   <= ovf_s;
                        out_valid_r <= 1'b1;
                        idx_r       <= '0;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign out_ovf   = out_ovf_r;
    assign add_a     = add_a_s;
    assign add_b     = add_b_s;
    assign add_cin   = add_cin_s;

endmodule
